// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: datapath widths, reset vector and fetch FSM states.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HALT
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding buffer for a fetch response that arrives while IF/ID is stalled.
module fetch_skid_buf
  import rv32_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic            i_pop,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic [ILEN-1:0] i_instr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [ILEN-1:0] o_instr
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [ILEN-1:0] r_instr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  // Payload is only observed while r_valid is set, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/pc_fetch_unit.sv
// RV32 instruction-fetch front end: PC, single-outstanding imem requests, IF/ID output slot
// with a one-entry skid buffer, and EX redirects that squash wrong-path fetches.
module pc_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr,
  output logic            misalign_trap,
  output logic [XLEN-1:0] trap_addr
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_discard;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [ILEN-1:0] r_if_instr;
  logic            r_trap;
  logic [XLEN-1:0] r_trap_addr;

  logic            w_accept;
  logic            w_consume;
  logic            w_rsp_live;
  logic            w_to_slot;
  logic            w_to_skid;
  logic            w_skid_pop;
  logic            w_if_valid_nxt;
  logic            w_skid_nxt;
  logic            w_discard_nxt;
  logic            w_issue;
  logic            w_outstanding;
  logic            w_redirect_ok;
  logic            w_skid_valid;
  logic [XLEN-1:0] w_skid_pc;
  logic [ILEN-1:0] w_skid_instr;

  assign w_accept      = (r_state == ST_REQ) && imem_ready;
  assign w_consume     = r_if_valid && !stall;
  assign w_rsp_live    = imem_rvalid && (r_state == ST_WAIT) && !r_discard;
  assign w_to_slot     = w_rsp_live && (!r_if_valid || !stall);
  assign w_to_skid     = w_rsp_live && !w_to_slot;
  assign w_skid_pop    = w_consume && w_skid_valid;
  assign w_redirect_ok = redirect_valid && is_word_aligned(redirect_pc);

  // Issue condition is judged on the state the slot, skid and discard flag will have next cycle.
  assign w_if_valid_nxt = w_to_slot || w_skid_pop || (r_if_valid && stall);
  assign w_skid_nxt     = w_to_skid || (w_skid_valid && !w_consume);
  assign w_discard_nxt  = r_discard && !imem_rvalid;
  assign w_issue        = !w_discard_nxt && !w_skid_nxt && !(w_if_valid_nxt && stall);

  // A request still owes a response if we wait on it, it was just accepted, or a stale one is pending.
  assign w_outstanding  = ((r_state == ST_WAIT) && !imem_rvalid) || w_accept || w_discard_nxt;

  fetch_skid_buf u_skid (
    .i_clk   (clk),
    .i_reset (reset),
    .i_load  (w_to_skid),
    .i_pop   (w_skid_pop),
    .i_flush (redirect_valid),
    .i_pc    (r_req_pc),
    .i_instr (imem_rdata),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_instr (w_skid_instr)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_req_pc <= r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_discard   <= 1'b0;
      r_if_valid  <= 1'b0;
      r_if_pc     <= '0;
      r_if_instr  <= '0;
      r_trap      <= 1'b0;
      r_trap_addr <= '0;
    end else begin
      r_trap <= 1'b0;
      if (redirect_valid) begin
        r_if_valid <= 1'b0;
        r_discard  <= w_outstanding;
        if (w_redirect_ok) begin
          r_pc    <= redirect_pc;
          r_state <= w_outstanding ? ST_IDLE : ST_REQ;
        end else begin
          r_trap      <= 1'b1;
          r_trap_addr <= redirect_pc;
          r_state     <= ST_HALT;
        end
      end else begin
        r_discard <= w_discard_nxt;
        if (w_to_slot) begin
          r_if_valid <= 1'b1;
          r_if_pc    <= r_req_pc;
          r_if_instr <= imem_rdata;
        end else if (w_skid_pop) begin
          r_if_valid <= 1'b1;
          r_if_pc    <= w_skid_pc;
          r_if_instr <= w_skid_instr;
        end else if (w_consume) begin
          r_if_valid <= 1'b0;
        end
        case (r_state)
          ST_IDLE: if (w_issue) r_state <= ST_REQ;
          ST_REQ: begin
            if (w_accept) begin
              r_pc    <= r_pc + XLEN'(4);
              r_state <= ST_WAIT;
            end
          end
          ST_WAIT: if (imem_rvalid) r_state <= w_issue ? ST_REQ : ST_IDLE;
          ST_HALT: r_state <= ST_HALT;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign imem_req      = (r_state == ST_REQ);
  assign imem_addr     = imem_req ? r_pc : '0;
  assign if_valid      = r_if_valid;
  assign if_pc         = r_if_pc;
  assign if_instr      = r_if_instr;
  assign misalign_trap = r_trap;
  assign trap_addr     = r_trap_addr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: latency-programmable imem model, address model and
// an output scoreboard fed at request acceptance and drained at IF/ID consumption.
module tb_pc_fetch_unit;
  import rv32_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;
  logic            misalign_trap;
  logic [XLEN-1:0] trap_addr;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic [31:0] exp_out[$];
  logic [31:0] model_addr = 32'h0;
  logic        req_ok = 1'b1;
  logic        acc_now = 1'b0;
  logic [31:0] acc_addr = 32'h0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  int          mem_lat = 1;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .misalign_trap  (misalign_trap),
    .trap_addr      (trap_addr)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Pre-edge view of the cycle: request acceptance, IF/ID consumption and redirects.
  task automatic monitor();
    logic [31:0] e;
    if (reset) begin
      acc_now    = 1'b0;
      model_addr = 32'h0;
      req_ok     = 1'b1;
      exp_out.delete();
      return;
    end
    acc_now  = imem_req && imem_ready;
    acc_addr = imem_addr;
    if (acc_now) begin
      check1("req_allowed", req_ok, 1'b1);
      check32("req_addr", imem_addr, model_addr);
      if (!redirect_valid) exp_out.push_back(model_addr);
      model_addr = model_addr + 32'd4;
    end
    if (if_valid && !stall && !redirect_valid) begin
      check1("out_expected", exp_out.size() != 0, 1'b1);
      if (exp_out.size() != 0) begin
        e = exp_out.pop_front();
        check32("if_pc", if_pc, e);
        check32("if_instr", if_instr, word_of(e));
        n_out++;
      end
    end
    if (redirect_valid) begin
      exp_out.delete();
      if (redirect_pc[1:0] == 2'b00) begin
        model_addr = redirect_pc;
        req_ok     = 1'b1;
      end else begin
        req_ok = 1'b0;
      end
    end
  endtask

  task automatic mem_update();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (reset) pend = 1'b0;
    if (acc_now) begin
      pend      = 1'b1;
      pend_cnt  = mem_lat;
      pend_addr = acc_addr;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(pend_addr);
        pend        = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    mem_update();
  endtask

  task automatic wait_acc(input logic [31:0] a, input int max, input string tag);
    int i = 0;
    do begin
      tick();
      i++;
    end while (!(acc_now && acc_addr == a) && i < max);
    check1(tag, acc_now && acc_addr == a, 1'b1);
  endtask

  task automatic wait_rvalid(input int max, input string tag);
    int i = 0;
    do begin
      tick();
      i++;
    end while (!imem_rvalid && i < max);
    check1(tag, imem_rvalid, 1'b1);
  endtask

  task automatic wait_ifvalid(input int max, input string tag);
    int i = 0;
    do begin
      tick();
      i++;
    end while (!if_valid && i < max);
    check1(tag, if_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    imem_ready     = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    #1;
    repeat (3) tick();
    check1("rst_req", imem_req, 1'b0);
    check32("rst_addr", imem_addr, 32'h0);
    check1("rst_if_valid", if_valid, 1'b0);
    check32("rst_if_pc", if_pc, 32'h0);
    check32("rst_if_instr", if_instr, 32'h0);
    check1("rst_trap", misalign_trap, 1'b0);
    check32("rst_trap_addr", trap_addr, 32'h0);

    // Zero-wait memory: 0, 4, 8 in order, one instruction every two cycles.
    reset = 1'b0;
    tick();
    check1("first_req", imem_req, 1'b1);
    check32("first_addr", imem_addr, 32'h0);
    repeat (6) tick();
    check1("seq_valid", if_valid, 1'b1);
    check32("seq_pc8", if_pc, 32'h8);
    check32("seq_addr12", imem_addr, 32'hC);

    // Stall for three cycles while the response for 0xC lands in the skid buffer.
    stall = 1'b1;
    tick();
    check32("stall_pc_a", if_pc, 32'h8);
    tick();
    check1("stall_noreq_a", imem_req, 1'b0);
    check32("stall_pc_b", if_pc, 32'h8);
    tick();
    check1("stall_noreq_b", imem_req, 1'b0);
    check32("stall_pc_c", if_pc, 32'h8);
    stall = 1'b0;
    tick();
    check32("skid_pc", if_pc, 32'hC);
    check32("skid_instr", if_instr, word_of(32'hC));
    check32("resume_addr", imem_addr, 32'h10);
    repeat (4) tick();

    // Redirect to 0x100 while the request for 0x8 is outstanding.
    reset   = 1'b1;
    mem_lat = 3;
    repeat (2) tick();
    reset = 1'b0;
    wait_acc(32'h8, 40, "acc8_seen");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check1("rd_if_valid", if_valid, 1'b0);
    check1("rd_hold_req", imem_req, 1'b0);
    wait_rvalid(10, "stale_rvalid");
    tick();
    check1("rd_new_req", imem_req, 1'b1);
    check32("rd_new_addr", imem_addr, 32'h100);
    check1("rd_dropped", if_valid, 1'b0);
    wait_ifvalid(20, "rd_out_seen");
    check32("rd_out_pc", if_pc, 32'h100);
    check32("rd_out_instr", if_instr, word_of(32'h100));

    // Redirect to 0x40 in the same cycle as rvalid with stall held.
    stall = 1'b1;
    wait_rvalid(20, "rv40_seen");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check1("r40_req", imem_req, 1'b1);
    check32("r40_addr", imem_addr, 32'h40);
    check1("r40_if_valid", if_valid, 1'b0);
    stall = 1'b0;
    wait_ifvalid(20, "r40_out_seen");
    check32("r40_out_pc", if_pc, 32'h40);

    // Misaligned redirect halts fetch until an aligned redirect arrives.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
    check1("trap_pulse", misalign_trap, 1'b1);
    check32("trap_addr", trap_addr, 32'h102);
    check1("trap_noreq", imem_req, 1'b0);
    check1("trap_if_valid", if_valid, 1'b0);
    tick();
    check1("trap_once", misalign_trap, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check1("halt_noreq", imem_req, 1'b0);
    end
    check32("trap_addr_held", trap_addr, 32'h102);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check1("resume_req", imem_req, 1'b1);
    check32("resume_200", imem_addr, 32'h200);
    wait_ifvalid(20, "r200_out_seen");
    check32("r200_out_pc", if_pc, 32'h200);

    // PC wraps from 0xFFFF_FFFC to 0.
    mem_lat        = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    wait_acc(32'hFFFF_FFFC, 20, "acc_top_seen");
    begin
      int i = 0;
      do begin
        tick();
        i++;
      end while (!acc_now && i < 20);
      check1("wrap_acc_seen", acc_now, 1'b1);
      check32("wrap_addr", acc_addr, 32'h0);
    end
    repeat (3) tick();

    // Reset in the middle of traffic.
    reset = 1'b1;
    tick();
    check1("mid_rst_req", imem_req, 1'b0);
    check1("mid_rst_valid", if_valid, 1'b0);
    check32("mid_rst_pc", if_pc, 32'h0);
    reset = 1'b0;
    tick();
    check1("post_rst_req", imem_req, 1'b1);
    check32("post_rst_addr", imem_addr, 32'h0);
    repeat (6) tick();

    check1("outputs_seen", n_out >= 8, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
